// File: rtl/mc_processor_p.sv
`default_nettype none
// ============================================================================
// Module   : mc_processor_p
// Brief    : Parametrised multicycle processor (FETCH/EXE/MEM/HALT/ERR) with
//            LD/ST/NOP/SET/ADD/JNZ/END, external instruction ROM and a
//            memory handshake (rwToMem + rdEn/wtEn).
//            Optional feature macro: MEM_TIMEOUT_EN (bounded MEM wait -> ERR).
// Revision : 1.0 - initial release
// ============================================================================
module mc_processor_p #(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 2,
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 64,
  parameter int INS_W   = 3 + 2*REG_W + WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  output logic [PC_W-1:0]   pcCounter,
  output logic [WORD_W-1:0] data,
  output logic              halted,
  output logic              error,
  output logic [1:0]        rwToMem,
  output logic [ADDR_W-1:0] addrToMem,
  output logic [WORD_W-1:0] dataToMem,
  input  logic              rdEn,
  input  logic              wtEn,
  input  logic [WORD_W-1:0] dataFromMem
);

  localparam int REGNUM = 2**REG_W;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXE   = 3'd1;
  localparam logic [2:0] ST_MEM   = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_ST  = 3'd1;
  localparam logic [2:0] OP_NOP = 3'd2;
  localparam logic [2:0] OP_SET = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_JNZ = 3'd5;
  localparam logic [2:0] OP_END = 3'd6;

  localparam logic [1:0] RW_IDLE = 2'd0;
  localparam logic [1:0] RW_RD   = 2'd1;
  localparam logic [1:0] RW_WT   = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [INS_W-1:0]  ir_q,    ir_d;
  logic [WORD_W-1:0] data_q,  data_d;
  logic [1:0]        rw_q,    rw_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [WORD_W-1:0] wdat_q,  wdat_d;
  logic [WORD_W-1:0] regs_q [REGNUM];
  logic [WORD_W-1:0] regs_d [REGNUM];

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // Instruction fields decoded from the latched IR
  logic [2:0]        op;
  logic [REG_W-1:0]  rd, rs;
  logic [WORD_W-1:0] imm;
  logic [WORD_W-1:0] sum;

  assign op  = ir_q[INS_W-1 -: 3];
  assign rd  = ir_q[WORD_W+REG_W +: REG_W];
  assign rs  = ir_q[WORD_W +: REG_W];
  assign imm = ir_q[WORD_W-1:0];
  assign sum = regs_q[rd] + regs_q[rs];

  // Next-state logic: sequencing, register file update, memory request
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    data_d  = data_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    regs_d  = regs_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_FETCH: begin
        ir_d    = ins;
        pc_d    = pc_q + 1'b1;
        state_d = ST_EXE;
      end
      ST_EXE: begin
        case (op)
          OP_LD: begin
            rw_d    = RW_RD;
            addr_d  = imm[ADDR_W-1:0];
            state_d = ST_MEM;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
          OP_ST: begin
            rw_d    = RW_WT;
            addr_d  = imm[ADDR_W-1:0];
            wdat_d  = regs_q[rd];
            state_d = ST_MEM;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
          OP_NOP: state_d = ST_FETCH;
          OP_SET: begin
            regs_d[rd] = imm;
            data_d     = imm;
            state_d    = ST_FETCH;
          end
          OP_ADD: begin
            regs_d[rd] = sum;
            data_d     = sum;
            state_d    = ST_FETCH;
          end
          OP_JNZ: begin
            if (regs_q[rd] != '0) pc_d = imm[PC_W-1:0];
            state_d = ST_FETCH;
          end
          OP_END:  state_d = ST_HALT;
          default: state_d = ST_ERR;
        endcase
      end
      ST_MEM: begin
        // Only the enable matching the pending op completes the access
        if (op == OP_LD && rdEn) begin
          regs_d[rd] = dataFromMem;
          data_d     = dataFromMem;
          rw_d       = RW_IDLE;
          state_d    = ST_FETCH;
        end else if (op == OP_ST && wtEn) begin
          rw_d       = RW_IDLE;
          state_d    = ST_FETCH;
        end
`ifdef MEM_TIMEOUT_EN
        // Last allowed cycle without an enable: abandon the access
        else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          rw_d    = RW_IDLE;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_HALT, ST_ERR: state_d = state_q;
      default: begin
        rw_d    = RW_IDLE;
        state_d = ST_ERR;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      data_q  <= '0;
      rw_q    <= RW_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      for (int i = 0; i < REGNUM; i++) regs_q[i] <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      for (int i = 0; i < REGNUM; i++) regs_q[i] <= regs_d[i];
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign pcCounter = pc_q;
  assign data      = data_q;
  assign halted    = (state_q == ST_HALT);
  assign error     = (state_q == ST_ERR);
  assign rwToMem   = rw_q;
  assign addrToMem = addr_q;
  assign dataToMem = wdat_q;

endmodule
`default_nettype wire
